// File: rtl/dma_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_engine
// Brief    : Multi-channel round-robin DMA mover. Each grant reads one burst
//            into a local buffer, then writes it back out to the destination.
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_CH-1:0]                           ch_start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                ch_src_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                ch_dst_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]                 ch_len,
    output logic [NUM_CH-1:0]                           ch_busy,
    output logic [NUM_CH-1:0]                           ch_done,
    output logic                                        rd_en,
    output logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic                                        rd_ready,
    input  logic [DATA_WIDTH-1:0]                       rd_data,
    output logic                                        wr_en,
    output logic [ADDR_WIDTH-1:0]                       wr_addr,
    output logic [DATA_WIDTH-1:0]                       wr_data,
    input  logic                                        wr_ready,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] active_ch
);

    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_BL_W = $clog2(MAX_BURST + 1);
    localparam int c_K_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src [NUM_CH];
    logic [ADDR_WIDTH-1:0] r_dst [NUM_CH];
    logic [LEN_WIDTH-1:0]  r_rem [NUM_CH];
    logic [NUM_CH-1:0]     r_busy;
    logic [NUM_CH-1:0]     r_done;
    logic [c_CH_W-1:0]     r_rr;
    logic [c_CH_W-1:0]     r_act;
    logic [c_BL_W-1:0]     r_blen;
    logic [c_K_W-1:0]      r_beat;
    logic [DATA_WIDTH-1:0] r_buf [MAX_BURST];

    logic [2*NUM_CH-1:0]   w_dbl;
    logic                  w_found;
    logic [c_CH_W-1:0]     w_grant;
    int                    w_sum;
    logic [LEN_WIDTH-1:0]  w_rem_g;
    logic [c_BL_W-1:0]     w_blen;
    logic                  w_last;
    logic [c_K_W-1:0]      w_beat_nxt;
    logic                  w_fin;
    logic [NUM_CH-1:0]     w_clear;
    logic [ADDR_WIDTH-1:0] w_step;

    assign ch_busy   = r_busy;
    assign ch_done   = r_done;
    assign active_ch = r_act;

    // Rotating the busy vector by rr_ptr turns the wrap-around search into a
    // plain lowest-set-bit search.
    assign w_dbl = {r_busy, r_busy} >> r_rr;

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && w_dbl[j]) begin
                w_found = 1'b1;
                w_sum   = int'(r_rr) + j;
                if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
                w_grant = c_CH_W'(w_sum);
            end
        end
    end

    assign w_rem_g    = r_rem[w_grant];
    assign w_blen     = (w_rem_g > LEN_WIDTH'(MAX_BURST)) ? c_BL_W'(MAX_BURST) : c_BL_W'(w_rem_g);
    assign w_last     = (c_BL_W'(r_beat) + c_BL_W'(1)) == r_blen;
    assign w_beat_nxt = r_beat + 1'b1;
    assign w_fin      = (r_rem[r_act] == LEN_WIDTH'(r_blen));
    assign w_step     = ADDR_WIDTH'(r_blen) * c_BYTES;

    always_comb begin
        w_clear        = '0;
        w_clear[r_act] = w_fin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= '0;
            r_done  <= '0;
            r_rr    <= '0;
            r_act   <= '0;
            r_blen  <= '0;
            r_beat  <= '0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_src[i] <= '0;
                r_dst[i] <= '0;
                r_rem[i] <= '0;
            end
            for (int i = 0; i < MAX_BURST; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= '0;

            // A channel in UPDATE is still busy, so starts never collide with it.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_start[i] && !r_busy[i]) begin
                    if (ch_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) begin
                        r_done[i] <= 1'b1;
                    end else begin
                        r_busy[i] <= 1'b1;
                        r_src[i]  <= ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        r_dst[i]  <= ch_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        r_rem[i]  <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (|r_busy) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_act   <= w_grant;
                        r_blen  <= w_blen;
                        r_beat  <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= r_src[w_grant];
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        r_buf[r_beat] <= rd_data;
                        if (w_last) begin
                            rd_en   <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_addr <= r_dst[r_act];
                            // Single-beat bursts have slot 0 arriving right now.
                            wr_data <= (r_beat == '0) ? rd_data : r_buf[0];
                            r_beat  <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_beat  <= w_beat_nxt;
                            rd_addr <= rd_addr + c_BYTES;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (w_last) begin
                            wr_en   <= 1'b0;
                            r_state <= S_UPDATE;
                        end else begin
                            r_beat  <= w_beat_nxt;
                            wr_addr <= wr_addr + c_BYTES;
                            wr_data <= r_buf[w_beat_nxt];
                        end
                    end
                end
                S_UPDATE: begin
                    r_src[r_act] <= r_src[r_act] + w_step;
                    r_dst[r_act] <= r_dst[r_act] + w_step;
                    r_rem[r_act] <= r_rem[r_act] - LEN_WIDTH'(r_blen);
                    if (w_fin) begin
                        r_busy[r_act] <= 1'b0;
                        r_done[r_act] <= 1'b1;
                    end
                    r_rr    <= (r_act == c_CH_W'(NUM_CH - 1)) ? '0 : r_act + 1'b1;
                    r_state <= ((r_busy & ~w_clear) != '0) ? S_ARB : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_burst_engine
// Brief    : Randomised self-checking bench for dma_burst_engine against a
//            burst-level round-robin copy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_burst_engine;

    localparam int MAXB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   ch_start;
    logic [127:0] ch_src_addr, ch_dst_addr;
    logic [63:0]  ch_len;
    logic [3:0]   ch_busy, ch_done;
    logic         rd_en, wr_en, rd_ready, wr_ready;
    logic [31:0]  rd_addr, rd_data, wr_addr, wr_data;
    logic [1:0]   active_ch;

    logic [31:0]  salt;
    bit           rand_rdy;
    int           n_chk, n_fail, m_rr;

    logic [31:0] t_src [4];
    logic [31:0] t_dst [4];
    int          t_len [4];

    logic [31:0] mq_rd[$], mq_wa[$], mq_wd[$];
    int          mq_wch[$], mq_grant[$], mq_blen[$];
    int          done_cnt [4];
    int          done_wr  [4];
    logic [31:0] e_rd[$], e_wa[$], e_wd[$];
    int          e_wch[$], e_grant[$], e_blen[$];
    int          e_done_wr [4];

    logic        p_rd_en, p_rd_stall, p_wr_stall;
    logic [31:0] p_rd_addr, p_wr_addr, p_wr_data;

    dma_burst_engine dut (
        .clk(clk), .rst_n(rst_n), .ch_start(ch_start),
        .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_len(ch_len),
        .ch_busy(ch_busy), .ch_done(ch_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    // Source memory: contents are a hash of the byte address.
    assign rd_data = (rd_addr * 32'h9E37_79B1) ^ salt;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            p_rd_en    <= 1'b0;
            p_rd_stall <= 1'b0;
            p_wr_stall <= 1'b0;
        end else begin
            n_chk++;
            if (rd_en && wr_en) begin
                n_fail++;
                $display("FAIL rd_wr_exclusive: rd_en=%b wr_en=%b, required never both 1", rd_en, wr_en);
            end
            if (p_rd_stall) begin
                n_chk++;
                if (rd_en !== 1'b1 || rd_addr !== p_rd_addr) begin
                    n_fail++;
                    $display("FAIL rd_stable: rd_en=%b rd_addr=%h, required 1 %h", rd_en, rd_addr, p_rd_addr);
                end
            end
            if (p_wr_stall) begin
                n_chk++;
                if (wr_en !== 1'b1 || wr_addr !== p_wr_addr || wr_data !== p_wr_data) begin
                    n_fail++;
                    $display("FAIL wr_stable: wr_en=%b addr=%h data=%h, required 1 %h %h",
                             wr_en, wr_addr, wr_data, p_wr_addr, p_wr_data);
                end
            end
            if (rd_en && !p_rd_en) begin
                mq_grant.push_back(int'(active_ch));
                mq_blen.push_back(0);
            end
            if (rd_en && rd_ready) begin
                mq_rd.push_back(rd_addr);
                if (mq_blen.size() > 0) mq_blen[mq_blen.size()-1] += 1;
            end
            if (wr_en && wr_ready) begin
                mq_wa.push_back(wr_addr);
                mq_wd.push_back(wr_data);
                mq_wch.push_back(int'(active_ch));
            end
            for (int i = 0; i < 4; i++) begin
                if (ch_done[i]) begin
                    done_cnt[i]++;
                    done_wr[i] = mq_wa.size();
                end
            end
            p_rd_en    <= rd_en;
            p_rd_stall <= rd_en && !rd_ready;
            p_wr_stall <= wr_en && !wr_ready;
            p_rd_addr  <= rd_addr;
            p_wr_addr  <= wr_addr;
            p_wr_data  <= wr_data;
        end
    end

    task automatic clear_mon();
        mq_rd.delete(); mq_wa.delete(); mq_wd.delete();
        mq_wch.delete(); mq_grant.delete(); mq_blen.delete();
        for (int i = 0; i < 4; i++) begin
            done_cnt[i] = 0;
            done_wr[i]  = 0;
        end
    endtask

    // Burst-level model: pick next busy channel from the pointer, copy up to
    // MAXB beats, advance the pointer past the granted channel.
    task automatic build_expect(input logic [3:0] mask);
        int          rem [4];
        logic [31:0] s [4];
        logic [31:0] d [4];
        int          g, b, p;
        e_rd.delete(); e_wa.delete(); e_wd.delete();
        e_wch.delete(); e_grant.delete(); e_blen.delete();
        for (int i = 0; i < 4; i++) begin
            rem[i]       = mask[i] ? t_len[i] : 0;
            s[i]         = t_src[i];
            d[i]         = t_dst[i];
            e_done_wr[i] = 0;
        end
        p = m_rr;
        while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
            g = -1;
            for (int j = 0; j < 4; j++)
                if (g < 0 && rem[(p + j) % 4] > 0) g = (p + j) % 4;
            b = (rem[g] < MAXB) ? rem[g] : MAXB;
            e_grant.push_back(g);
            e_blen.push_back(b);
            for (int k = 0; k < b; k++) begin
                e_rd.push_back(s[g] + 32'(4 * k));
                e_wa.push_back(d[g] + 32'(4 * k));
                e_wd.push_back(mem_f(s[g] + 32'(4 * k)));
                e_wch.push_back(g);
            end
            s[g]   += 32'(4 * b);
            d[g]   += 32'(4 * b);
            rem[g] -= b;
            if (rem[g] == 0) e_done_wr[g] = e_wa.size();
            p = (g + 1) % 4;
        end
        m_rr = p;
    endtask

    task automatic test_transfer(input logic [3:0] mask, input bit poke, input string name);
        int cyc;
        bit ok;
        build_expect(mask);
        clear_mon();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ch_src_addr[i*32 +: 32] = t_src[i];
            ch_dst_addr[i*32 +: 32] = t_dst[i];
            ch_len[i*16 +: 16]      = 16'(t_len[i]);
        end
        ch_start = mask;
        @(posedge clk); #1;
        ch_start = '0;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                ch_src_addr[i*32 +: 32] = $urandom;
                ch_dst_addr[i*32 +: 32] = $urandom;
                ch_len[i*16 +: 16]      = 16'd2;
            end
            ch_start = mask;
            @(posedge clk); #1;
            ch_start = '0;
        end
        ok = 1'b0;
        for (cyc = 0; cyc < 4000 && !ok; cyc++) begin
            @(negedge clk);
            ok = (ch_busy == 4'b0);
            for (int i = 0; i < 4; i++) if (mask[i] && done_cnt[i] == 0) ok = 1'b0;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required all done", name, ch_busy, cyc);
        end
        repeat (12) @(negedge clk);

        n_chk++;
        if (mq_rd.size() != e_rd.size()) begin
            n_fail++;
            $display("FAIL %s rd_count: got %0d required %0d", name, mq_rd.size(), e_rd.size());
        end
        foreach (e_rd[i]) if (i < mq_rd.size()) begin
            n_chk++;
            if (mq_rd[i] !== e_rd[i]) begin
                n_fail++;
                $display("FAIL %s rd_addr[%0d]: got %h required %h", name, i, mq_rd[i], e_rd[i]);
            end
        end
        n_chk++;
        if (mq_wa.size() != e_wa.size()) begin
            n_fail++;
            $display("FAIL %s wr_count: got %0d required %0d", name, mq_wa.size(), e_wa.size());
        end
        foreach (e_wa[i]) if (i < mq_wa.size()) begin
            n_chk++;
            if (mq_wa[i] !== e_wa[i] || mq_wd[i] !== e_wd[i] || mq_wch[i] != e_wch[i]) begin
                n_fail++;
                $display("FAIL %s wr_beat[%0d]: got %h/%h ch%0d required %h/%h ch%0d",
                         name, i, mq_wa[i], mq_wd[i], mq_wch[i], e_wa[i], e_wd[i], e_wch[i]);
            end
        end
        n_chk++;
        if (mq_grant.size() != e_grant.size()) begin
            n_fail++;
            $display("FAIL %s burst_count: got %0d required %0d", name, mq_grant.size(), e_grant.size());
        end
        foreach (e_grant[i]) if (i < mq_grant.size()) begin
            n_chk++;
            if (mq_grant[i] != e_grant[i] || mq_blen[i] != e_blen[i]) begin
                n_fail++;
                $display("FAIL %s burst[%0d]: got ch%0d len %0d required ch%0d len %0d",
                         name, i, mq_grant[i], mq_blen[i], e_grant[i], e_blen[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (done_cnt[i] != int'(mask[i])) begin
                n_fail++;
                $display("FAIL %s done_count[%0d]: got %0d required %0d", name, i, done_cnt[i], int'(mask[i]));
            end
            if (mask[i]) begin
                n_chk++;
                if (done_wr[i] != e_done_wr[i]) begin
                    n_fail++;
                    $display("FAIL %s done_timing[%0d]: writes before done %0d required %0d",
                             name, i, done_wr[i], e_done_wr[i]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_chk++;
        if (ch_busy !== 4'b0 || ch_done !== 4'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 ||
            rd_addr !== 32'b0 || wr_addr !== 32'b0 || wr_data !== 32'b0 || active_ch !== 2'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%h wr_addr=%h wr_data=%h act=%0d, required all 0",
                     name, ch_busy, ch_done, rd_en, wr_en, rd_addr, wr_addr, wr_data, active_ch);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_start = '0; ch_src_addr = '0; ch_dst_addr = '0; ch_len = '0;
        rd_ready = 1'b1; wr_ready = 1'b1; rand_rdy = 1'b0; salt = $urandom; m_rr = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_round_robin();
        t_src[0] = 32'h0000_0100; t_dst[0] = 32'h2000_0000; t_len[0] = 16;
        t_src[2] = 32'h0000_8000; t_dst[2] = 32'h3000_0000; t_len[2] = 16;
        test_transfer(4'b0101, 1'b0, "v3_round_robin");
        n_chk++;
        if (mq_grant.size() != 4 || mq_grant[0] != 0 || mq_grant[1] != 2 || mq_grant[2] != 0 || mq_grant[3] != 2) begin
            n_fail++;
            $display("FAIL v3_grant_order: got %0d grants, required ch0 ch2 ch0 ch2", mq_grant.size());
        end
    endtask

    task automatic test_single();
        t_src[0] = 32'h0; t_dst[0] = 32'h1000_0000; t_len[0] = 4;
        test_transfer(4'b0001, 1'b0, "v1_single");
    endtask

    task automatic test_multi_burst();
        t_src[1] = 32'h0; t_dst[1] = 32'h0004_0000; t_len[1] = 20;
        test_transfer(4'b0010, 1'b0, "v2_multi_burst");
        n_chk++;
        if (mq_rd.size() < 20 || mq_rd[0] !== 32'h0 || mq_rd[8] !== 32'h20 || mq_rd[16] !== 32'h40) begin
            n_fail++;
            $display("FAIL v2_burst_bases: got %0d reads, required bases 0 20 40", mq_rd.size());
        end
    endtask

    task automatic test_random_ready();
        rand_rdy = 1'b1;
        t_src[0] = 32'h0; t_dst[0] = 32'h1000_0000; t_len[0] = 4;
        test_transfer(4'b0001, 1'b0, "v4_random_ready");
        t_src[3] = $urandom; t_dst[3] = $urandom; t_len[3] = 13;
        test_transfer(4'b1000, 1'b0, "v4_random_ready_long");
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        rd_ready = 1'b1; wr_ready = 1'b1;
    endtask

    task automatic test_addr_wrap();
        t_src[2] = 32'hFFFF_FFF8; t_dst[2] = 32'hFFFF_FFFC; t_len[2] = 4;
        test_transfer(4'b0100, 1'b0, "v5_addr_wrap");
        n_chk++;
        if (mq_rd.size() != 4 || mq_rd[0] !== 32'hFFFF_FFF8 || mq_rd[1] !== 32'hFFFF_FFFC ||
            mq_rd[2] !== 32'h0 || mq_rd[3] !== 32'h4) begin
            n_fail++;
            $display("FAIL v5_wrap_reads: got %0d reads, required FFFFFFF8 FFFFFFFC 0 4", mq_rd.size());
        end
    endtask

    task automatic test_ignore_busy_start();
        t_src[0] = 32'h0000_4000; t_dst[0] = 32'h0000_9000; t_len[0] = 12;
        test_transfer(4'b0001, 1'b1, "busy_start_ignored");
    endtask

    task automatic test_restart();
        int cyc;
        t_src[3] = 32'h40; t_dst[3] = 32'h80; t_len[3] = 3;
        clear_mon();
        @(posedge clk); #1;
        ch_src_addr[96 +: 32] = t_src[3]; ch_dst_addr[96 +: 32] = t_dst[3]; ch_len[48 +: 16] = 16'd3;
        ch_start = 4'b1000;
        @(posedge clk); #1;
        ch_start = '0;
        for (cyc = 0; cyc < 500 && ch_done[3] !== 1'b1; cyc++) @(negedge clk);
        n_chk++;
        if (ch_done[3] !== 1'b1 || ch_busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done_cycle: done=%b busy=%b, required 1 0", ch_done[3], ch_busy[3]);
        end
        ch_src_addr[96 +: 32] = 32'h500; ch_len[48 +: 16] = 16'd5;
        ch_start = 4'b1000;
        @(posedge clk); #1;
        ch_start = '0;
        @(negedge clk);
        n_chk++;
        if (ch_busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_accept: busy=%b, required 1", ch_busy[3]);
        end
        for (cyc = 0; cyc < 1000 && ch_busy !== 4'b0; cyc++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_chk++;
        if (mq_rd.size() != 8 || done_cnt[3] != 2 || mq_rd[3] !== 32'h500) begin
            n_fail++;
            $display("FAIL restart_transfer: reads=%0d dones=%0d, required 8 reads 2 dones 4th read at 500",
                     mq_rd.size(), done_cnt[3]);
        end
        m_rr = 0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] mask;
        for (int r = 0; r < 6; r++) begin
            salt     = $urandom;
            rand_rdy = (r % 2 == 1);
            mask     = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                t_src[i] = $urandom;
                t_dst[i] = $urandom;
                t_len[i] = $urandom_range(0, 20);
            end
            test_transfer(mask, 1'b0, "back_to_back");
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        rd_ready = 1'b1; wr_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_mon();
        @(posedge clk); #1;
        ch_src_addr[32 +: 32] = 32'h200; ch_dst_addr[32 +: 32] = 32'h3000; ch_len[16 +: 16] = 16'd8;
        ch_start = 4'b0010;
        @(posedge clk); #1;
        ch_start = '0;
        for (cyc = 0; cyc < 200 && wr_en !== 1'b1; cyc++) @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL v6_reach_write: wr_en=%b, required 1", wr_en);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("v6_async_reset");
        m_rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        n_chk++;
        if (mq_rd.size() != 0 || mq_wa.size() != 0 || ch_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL v6_discarded: reads=%0d writes=%0d busy=%b, required 0 0 0", mq_rd.size(), mq_wa.size(), ch_busy);
        end
        @(posedge clk); #1;
        ch_len[32 +: 16] = 16'd0;
        ch_start = 4'b0100;
        @(posedge clk); #1;
        ch_start = '0;
        @(negedge clk);
        n_chk++;
        if (ch_done !== 4'b0100 || ch_busy !== 4'b0) begin
            n_fail++;
            $display("FAIL v6_zero_len_done: done=%b busy=%b, required 0100 0000", ch_done, ch_busy);
        end
        @(negedge clk);
        n_chk++;
        if (ch_done !== 4'b0) begin
            n_fail++;
            $display("FAIL v6_zero_len_pulse: done=%b, required 0000", ch_done);
        end
        repeat (5) @(negedge clk);
        n_chk++;
        if (mq_rd.size() != 0 || mq_wa.size() != 0) begin
            n_fail++;
            $display("FAIL v6_zero_len_beats: reads=%0d writes=%0d, required 0 0", mq_rd.size(), mq_wa.size());
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_multi_burst();
        test_random_ready();
        test_addr_wrap();
        test_ignore_busy_start();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
